// File: rtl/calc_pkg.sv
// Shared calculator definitions: result width, display digit count and the
// sequencer state type used by the binary-to-BCD converter.
package calc_pkg;

   localparam int RES_W      = 14;
   localparam int BCD_DIGITS = 5;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_adj3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // add 3 to digits >= 5, pass the rest through
   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// cycle. Results are held on bcd/sinal_out/ovf4 until the next completion.
module bin2bcd_seq
   import calc_pkg::*;
#(
   parameter int W      = RES_W,
   parameter int DIGITS = BCD_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [W-1:0]          Y,
   input  logic                  sinal,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  sinal_out,
   output logic                  ovf4
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_t               state;
   state_t               state_n;
   logic [CW-1:0]        cnt;
   logic [W-1:0]         sreg;
   logic [4*DIGITS-1:0]  scratch;
   logic [4*DIGITS-1:0]  adj;
   logic                 sign_l;
   logic                 last;
   logic                 hi_nz;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_adj3 u_adj (
         .din  (scratch[4*i +: 4]),
         .dout (adj[4*i +: 4])
      );
   end

   // any digit above the four displayable ones marks the value as > 9999
   if (DIGITS > 4) begin : g_ovf
      assign hi_nz = |scratch[4*DIGITS-1:16];
   end else begin : g_noovf
      assign hi_nz = 1'b0;
   end

   assign last = (cnt == CW'(W - 1));

   // next-state selection and busy flag
   always_comb begin
      state_n = state;
      busy    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) begin
               state_n = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // state, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sreg      <= '0;
         scratch   <= '0;
         sign_l    <= 1'b0;
         bcd       <= '0;
         sinal_out <= 1'b0;
         ovf4      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_n;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sreg    <= Y;
                  sign_l  <= sinal;
                  scratch <= '0;
                  cnt     <= '0;
               end
            end
            SHIFT: begin
               {scratch, sreg} <= {adj, sreg} << 1;
               cnt             <= cnt + 1'b1;
            end
            DONE: begin
               bcd       <= scratch;
               sinal_out <= sign_l;
               ovf4      <= hi_nz;
               done      <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
